// File: rtl/aes128_key_expander.sv
// AES-128 key schedule generator.
// Captures a 128-bit cipher key on start and streams round keys 0..10 over a
// valid/ready handshake, computing each next round key from the current one
// with a single 32-bit SubWord evaluation per cycle.

// Single AES S-box byte lookup.
module aes_sbox (
    input  logic [7:0] byteIn,
    output logic [7:0] byteOut
);
    // Forward S-box, row-major: element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byteOut = SBOX[byteIn];
endmodule

// 32-bit word substitution: one S-box per byte lane.
module aes_subword #(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0][7:0] wordIn,
    output logic [NUM_LANES-1:0][7:0] wordOut
);
    for (genvar g = 0; g < NUM_LANES; g++) begin : genLane
        aes_sbox uSbox (
            .byteIn  (wordIn[g]),
            .byteOut (wordOut[g])
        );
    end
endmodule

module aes128_key_expander (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t      state;
    state_t      nextState;
    logic [7:0]  rcon;
    logic        doneQ;
    logic        accept;
    logic        lastBeat;
    logic        startAccept;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rotW;
    logic [31:0] subW;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign accept      = (state == RUN) && rk_ready;
    assign lastBeat    = accept && (rk_index == LAST_ROUND);
    assign startAccept = (state == IDLE) && start;

    // Next round key from the current one; only consumed on an accepted beat.
    assign {w0, w1, w2, w3} = rk;
    assign rotW = {w3[23:0], w3[31:24]};

    aes_subword #(.NUM_LANES(4)) uSubWord (
        .wordIn  (rotW),
        .wordOut (subW)
    );

    assign temp = subW ^ {rcon, 24'h0};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic: IDLE waits for start, RUN ends after round 10 is taken.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start)    nextState = RUN;
            RUN:  if (lastBeat) nextState = IDLE;
            default:            nextState = IDLE;
        endcase
    end

    // Outputs decoded from state; a round key is presented for the whole RUN.
    always_comb begin
        busy     = (state == RUN);
        rk_valid = (state == RUN);
    end

    // Round-key datapath, round counter, rcon and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rk       <= '0;
            rk_index <= '0;
            rcon     <= 8'h01;
            doneQ    <= 1'b0;
        end else begin
            doneQ <= lastBeat;
            if (startAccept) begin
                rk       <= key;
                rk_index <= '0;
                rcon     <= 8'h01;
            end else if (accept && !lastBeat) begin
                rk       <= {n0, n1, n2, n3};
                rk_index <= rk_index + 4'd1;
                rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
        end
    end

    assign done = doneQ;
endmodule

// File: tb/tb_aes128_key_expander.sv
// Self-checking bench for aes128_key_expander: a behavioural key-schedule
// model (S-box derived from GF(2^8) inversion plus affine map) is compared
// against the DUT stream every cycle under random backpressure and noise.
module tb_aes128_key_expander;
    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

    aes128_key_expander dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .rk_index (rk_index),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Full FIPS-197 expansion into 44 words, returning round key r.
    function automatic logic [127:0] roundKey(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Protocol-level model state, advanced on each rising edge.
    logic         mLive = 1'b0;
    logic         mBusy = 1'b0;
    logic         mDone = 1'b0;
    logic         mRst  = 1'b0;
    int           mIdx  = 0;
    logic [127:0] mKey  = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mBusy = 1'b0; mDone = 1'b0; mIdx = 0; mRst = 1'b1; mLive = 1'b1;
            end else if (mLive) begin
                mRst = 1'b0;
                mDone = 1'b0;
                if (!mBusy) begin
                    if (start) begin
                        mKey = key; mIdx = 0; mBusy = 1'b1;
                    end
                end else if (rk_ready) begin
                    if (mIdx == 10) begin
                        mBusy = 1'b0; mDone = 1'b1;
                    end else begin
                        mIdx++;
                    end
                end
            end
        end
    end

    // Compare process: outputs checked on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mLive) begin
                check("busy", 128'(busy), 128'(mBusy));
                check("rk_valid", 128'(rk_valid), 128'(mBusy));
                check("done", 128'(done), 128'(mDone));
                check("doneWithValid", 128'(done & rk_valid), 128'(0));
                if (mBusy) begin
                    check("rk_index", 128'(rk_index), 128'(mIdx));
                    check("rk", rk, roundKey(mKey, mIdx));
                end
                if (mRst) begin
                    check("resetRk", rk, 128'(0));
                    check("resetIndex", 128'(rk_index), 128'(0));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Starts an expansion from the current time (posedge+2), returns in the
    // done cycle with lat = edges from start sample to done (0 on timeout).
    task automatic runExp(input logic [127:0] k, input bit randReady, input bit noise, output int lat);
        start = 1'b1;
        key = k;
        rk_ready = randReady ? 1'($urandom % 2) : 1'b1;
        lat = 0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            rk_ready = randReady ? 1'($urandom % 2) : 1'b1;
            if (noise) begin
                key = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom % 4 == 0) start = 1'b1;
            end
        end
        if (lat == 0) begin
            tests++; fails++;
            $display("FAIL timeout: no done within 400 cycles for key %h", k);
        end
    endtask

    int lat;

    initial begin
        reset = 1'b1; start = 1'b0; key = '0; rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Pin the model against FIPS-197 vectors.
        check("modelA1r0", roundKey(KEY_A1, 0), KEY_A1);
        check("modelA1r1", roundKey(KEY_A1, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        check("modelA1r2", roundKey(KEY_A1, 2), 128'hf2c295f27a96b9435935807a7359f67f);
        check("modelA1r10", roundKey(KEY_A1, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("modelC1r10", roundKey(KEY_C1, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("modelZeroR1", roundKey(128'h0, 1), 128'h62636363626363636263636362636363);

        repeat (2) @(posedge clk);
        #2;

        // A.1 at full throughput: done exactly 12 cycles after start sample.
        runExp(KEY_A1, 1'b0, 1'b0, lat);
        check("latencyA1", 128'(lat), 128'(12));

        // Back-to-back: start held in the done cycle.
        runExp(KEY_C1, 1'b0, 1'b0, lat);
        check("latencyB2B", 128'(lat), 128'(12));
        @(posedge clk); #2;

        // Random backpressure plus ignored start/key noise during RUN.
        runExp(KEY_A1, 1'b1, 1'b1, lat);
        @(posedge clk); #2;

        // Zero key with random backpressure.
        runExp(128'h0, 1'b1, 1'b0, lat);
        @(posedge clk); #2;

        // Reset while round 5 is presented.
        start = 1'b1; key = KEY_A1; rk_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (rk_index == 4'd5) break;
        end
        check("reachedIndex5", 128'(rk_index), 128'(5));
        reset = 1'b1; start = 1'b1; key = KEY_C1;
        @(posedge clk); #2;
        reset = 1'b0; start = 1'b0;
        check("postResetValid", 128'(rk_valid), 128'(0));
        check("postResetBusy", 128'(busy), 128'(0));
        check("postResetIndex", 128'(rk_index), 128'(0));
        runExp(KEY_A1, 1'b1, 1'b0, lat);
        @(posedge clk); #2;

        // Random keys, random backpressure and noise.
        for (int i = 0; i < 6; i++) begin
            runExp({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, lat);
            repeat ($urandom % 3) @(posedge clk);
            #0;
        end

        rk_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes128_key_expander.md
# aes128_key_expander

Sequential AES-128 key schedule generator, per FIPS-197 §5.2. On `start` it captures a 128-bit cipher key and emits the 11 round keys (round 0 to round 10) as a valid/ready stream, one round key per accepted beat. It sits directly downstream of the 32-bit word substitution block: it drives that block with RotWord(w[i-1]) and consumes the SubWord result. Its round-key stream feeds the AddRoundKey stage of the cipher datapath.

## Interface
Parameters:
- none (fixed AES-128: Nk=4, Nr=10).

Ports (clk and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  request expansion of `key`; sampled only in IDLE.
- `key`  in  128  cipher key; byte 0 = bits [127:120]; captured only in the cycle `start` is accepted.
- `rk_ready`  in  1  consumer accepts the current round key.
- `rk_valid`  out  1  `rk`/`rk_index` hold a valid round key.
- `rk`  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] = bits [127:96].
- `rk_index`  out  4  round number r, 0 to 10.
- `busy`  out  1  expansion in progress (state RUN).
- `done`  out  1  one-cycle pulse after round key 10 is accepted.

## Operation
- States: IDLE and RUN.
- IDLE: `busy`=0, `rk_valid`=0.
  - `start`=1 → capture `key` into `rk`, set `rk_index`=0 and rcon=8'h01, set `rk_valid`=1 and `busy`=1, go to RUN.
- RUN: a beat is accepted when `rk_valid`&`rk_ready`.
  - Beat accepted with `rk_index`<10 → load the next round key, `rk_index`+1, rcon=xtime(rcon).
  - Beat accepted with `rk_index`=10 → go to IDLE; `rk_valid`=0, `busy`=0, `done`=1 for exactly one cycle.
  - No beat accepted → `rk`, `rk_index`, rcon and `rk_valid` hold unchanged.
- Next-round-key datapath (combinational from the current `rk`, evaluated in the accept cycle):
  - Split the current `rk` into words w0..w3.
  - t = SubWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- Rcon arithmetic: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - Sequence per round 1..10: 01,02,04,08,10,20,40,80,1b,36.
- Only one SubWord evaluation per cycle (one 32-bit substitution instance).
- `start` while `busy`=1 is ignored; the in-flight expansion is not disturbed and `key` is not resampled.
- `key` changes after capture have no effect.

## Timing
- Reset values: `rk_valid`=0, `busy`=0, `done`=0, `rk`=0, `rk_index`=0, rcon=8'h01, state IDLE.
- `reset` overrides everything, including mid-expansion and a simultaneous `start`. The cycle after reset is deasserted is IDLE.
- `start` sampled at edge T → round key 0 is visible, with `rk_valid`=1, after edge T.
- With `rk_ready` held 1: round key r is visible in cycle T+1+r. Round 10 is in cycle T+11; `done`=1 in cycle T+12.
- `done` and `busy`=0 coincide. `start` may be asserted in the `done` cycle; it is accepted (state is IDLE), giving back-to-back expansions with no dead cycle.
- Stall: while `rk_ready`=0, outputs hold stable for any number of cycles. Latency is 11 accepted beats plus the stall cycles.
- `done` is never asserted together with `rk_valid`.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → expected stream:
  - r0 = key.
  - r1 = a0fafe1788542cb123a339392a6c7605.
  - r2 = f2c295f27a96b9435935807a7359f67f.
  - r10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` pulse exactly at T+12.
- Same key, `rk_ready` toggled pseudo-randomly → identical 11-key sequence; `rk`/`rk_index` stable during every stall; no index skipped or repeated.
- `start` pulses during RUN, with a different `key` → ignored; sequence still matches A.1.
- `reset` asserted while `rk_index`=5 → next cycle `rk_valid`=0, `busy`=0, `rk_index`=0; a new `start` restarts from r0.
- `start` held in the `done` cycle with key 000102030405060708090a0b0c0d0e0f → new r0 appears the next cycle; r10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Key all zeros → r1 = 62636363626363636263636362636363. This exercises the rcon/SubWord path from the zero input.
